// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: streams one WORD_W slice per cycle (LSW first)
// through an external CLA, chaining its carry-out, and returns sum/carry/overflow.
module wide_add_sequencer #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in_a,
    input  logic [WORD_W*NUM_WORDS-1:0] in_b,
    input  logic                        in_cin,
    input  logic                        in_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_sum,
    output logic                        out_cout,
    output logic                        out_ovf,
    output logic [WORD_W-1:0]           cla_a,
    output logic [WORD_W-1:0]           cla_b,
    output logic                        cla_cin,
    input  logic [WORD_W-1:0]           cla_s,
    input  logic                        cla_cout
);
    localparam int N     = WORD_W * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    // B is stored already inverted for subtract so RUN never looks at in_sub
                    a_d        = in_a;
                    b_d        = in_b ^ {N{in_sub}};
                    carry_d    = in_sub | in_cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*WORD_W +: WORD_W] = cla_s;
                carry_d = cla_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d      = cla_cout;
                    ovf_d       = (a_q[N-1] == b_q[N-1]) && (cla_s[WORD_W-1] != a_q[N-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // CLA operands come straight from registers; idx_q parks on the last slice in DONE
    assign cla_a     = a_q[int'(idx_q)*WORD_W +: WORD_W];
    assign cla_b     = b_q[int'(idx_q)*WORD_W +: WORD_W];
    assign cla_cin   = carry_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer (64-bit build) with a behavioural 16-bit CLA attached.
module tb_wide_add_sequencer;
    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 4;
    localparam int N         = WORD_W * NUM_WORDS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N-1:0]      in_a = '0;
    logic [N-1:0]      in_b = '0;
    logic              in_cin = 1'b0;
    logic              in_sub = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N-1:0]      out_sum;
    logic              out_cout;
    logic              out_ovf;
    logic [WORD_W-1:0] cla_a;
    logic [WORD_W-1:0] cla_b;
    logic              cla_cin;
    logic [WORD_W-1:0] cla_s;
    logic              cla_cout;

    always #5 clk = ~clk;

    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {{WORD_W{1'b0}}, cla_cin};

    wide_add_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
        .cla_s(cla_s), .cla_cout(cla_cout)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: subtraction via native '-' and unsigned compare for no-borrow.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                         output logic [63:0] s, output logic c, output logic o);
        logic [64:0] r;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            o = (a[63] != b[63]) && (s[63] != a[63]);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            s = r[63:0];
            c = r[64];
            o = (a[63] == b[63]) && (s[63] != a[63]);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                          input int rdy_dly, input bit early,
                          output logic [63:0] s, output logic c, output logic o, output int lat);
        int w;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = early;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_seen", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
        s = out_sum; c = out_cout; o = out_ovf;
        for (int i = 0; i < rdy_dly; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
        end
        if (rdy_dly > 0) chk("held_sum", out_sum, s);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] s, es;
        logic        c, o, ec, eo;
        int          lat;
        int          w;
        bit          bad;

        vecs[0]  = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[5]  = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
        vecs[6]  = '{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[7]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[9]  = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};
        vecs[10] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[11] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_cout_ovf", {62'd0, out_cout, out_ovf}, 64'd0);
        chk("rst_cla", {31'd0, cla_cin, cla_a, cla_b}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, (i % 3) == 2, s, c, o, lat);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), {63'd0, c}, {63'd0, vecs[i].cout});
            chk($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].ovf});
            chk($sformatf("vec%0d_latency", i), lat, 5);
        end

        // Backpressure: result must hold and a pending request must wait.
        @(negedge clk);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd1);
        in_a = vecs[9].a; in_b = vecs[9].b; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        in_a = 64'h5; in_b = 64'h7; in_sub = 1'b1; in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_sum !== vecs[9].sum || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        chk("bp_hold_stable", {63'd0, bad}, 64'd0);
        chk("bp_sum", out_sum, vecs[9].sum);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_ready_after_drain", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_second_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("bp_second_cout", {63'd0, out_cout}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while the third slice is in the CLA.
        @(negedge clk);
        in_a = vecs[1].a; in_b = vecs[1].b; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_sum", out_sum, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        chk("midrst_quiet", {63'd0, bad}, 64'd0);
        run_op(vecs[7].a, vecs[7].b, vecs[7].cin, vecs[7].sub, 0, 1'b0, s, c, o, lat);
        chk("midrst_next_sum", s, vecs[7].sum);
        chk("midrst_next_flags", {62'd0, c, o}, {62'd0, vecs[7].cout, vecs[7].ovf});

        // Random operations with random consumer delay and idle gaps.
        for (int i = 0; i < 200; i++) begin
            logic [63:0] ra, rb;
            logic        rc, rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 0) rb = ~ra;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rs, es, ec, eo);
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0, s, c, o, lat);
            chk($sformatf("rnd%0d_sum", i), s, es);
            chk($sformatf("rnd%0d_flags", i), {62'd0, c, o}, {62'd0, ec, eo});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
